// File: rtl/eviction_write_buffer_drain.sv
// Drain side of the single-entry eviction write buffer.
// Writes the buffered dirty line back to pmem, forwards cache line reads to
// pmem, and serves reads that hit the buffered line straight from the buffer.
// Reads take priority over drains until MAX_BYPASS reads have been serviced
// while the buffer is valid; after that the next decision forces a drain.
module eviction_write_buffer_drain #(
    parameter int unsigned OFFSET_BITS = 5,
    parameter int unsigned MAX_BYPASS  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    // eviction buffer side
    input  logic         buf_valid,
    input  logic [255:0] buf_wdata,
    input  logic [31:0]  buf_address,
    output logic         complete_eviction,
    // cache miss path
    input  logic         l2_read,
    input  logic [31:0]  l2_address,
    output logic [255:0] l2_rdata,
    output logic         l2_resp,
    output logic         buf_hit,
    // physical memory
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int unsigned CNT_W = $clog2(MAX_BYPASS + 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        FWD,
        WRITE
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic [255:0]       line_data_q, line_data_d;
    logic [CNT_W-1:0]   bypass_cnt_q, bypass_cnt_d;
    logic               bypass_ok;
    logic               unused_offset_bits;

    // Only the line portion of the addresses takes part in matching.
    assign unused_offset_bits = ^{buf_address[OFFSET_BITS-1:0], l2_address[OFFSET_BITS-1:0]};

    // Read hits the buffered line: combinational, independent of FSM state.
    assign buf_hit = buf_valid & l2_read &
                     (buf_address[31:OFFSET_BITS] == l2_address[31:OFFSET_BITS]);

    // A read may bypass a pending drain only while under the starvation limit.
    assign bypass_ok = !buf_valid || (bypass_cnt_q < CNT_W'(MAX_BYPASS));

    // Next-state and register update logic for the drain/read arbiter.
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        line_data_d  = line_data_q;
        bypass_cnt_d = bypass_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (buf_hit) begin
                    line_data_d = buf_wdata;
                    state_d     = FWD;
                end else if (l2_read && bypass_ok) begin
                    req_addr_d = l2_address;
                    state_d    = READ;
                    if (buf_valid) begin
                        bypass_cnt_d = bypass_cnt_q + CNT_W'(1);
                    end
                end else if (buf_valid) begin
                    req_addr_d  = buf_address;
                    line_data_d = buf_wdata;
                    state_d     = WRITE;
                end
            end
            FWD: begin
                state_d = IDLE;
            end
            READ: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (pmem_resp) begin
                    bypass_cnt_d = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched transaction registers; reset abandons any pmem access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            line_data_q  <= '0;
            bypass_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            line_data_q  <= line_data_d;
            bypass_cnt_q <= bypass_cnt_d;
        end
    end

    // Output decode from registered state; completions follow pmem_resp directly.
    always_comb begin
        pmem_read         = (state_q == READ);
        pmem_write        = (state_q == WRITE);
        pmem_address      = req_addr_q;
        pmem_wdata        = line_data_q;
        l2_resp           = 1'b0;
        l2_rdata          = '0;
        complete_eviction = 1'b0;
        if (state_q == FWD) begin
            l2_resp  = 1'b1;
            l2_rdata = line_data_q;
        end else if (state_q == READ && pmem_resp) begin
            l2_resp  = 1'b1;
            l2_rdata = pmem_rdata;
        end else if (state_q == WRITE && pmem_resp) begin
            complete_eviction = 1'b1;
        end
    end

endmodule

// File: doc/eviction_write_buffer_drain.md
Name: eviction_write_buffer_drain

Overview:
- Drain side of the single-entry eviction write buffer; sits between the buffer, the cache miss path, and physical memory (pmem).
- Writes the buffered dirty line back to pmem and pulses complete_eviction so the buffer clears.
- Forwards cache line reads to pmem, or serves them directly from the buffer when the address hits the buffered line.
- Read misses have priority over drains, bounded by a starvation limit.

Parameters:
- OFFSET_BITS, 5, byte-offset bits of a 256-bit line; line match compares address[31:OFFSET_BITS].
- MAX_BYPASS, 4, maximum pmem reads serviced while the buffer is valid before a drain is forced.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous and active-low.
- buf_valid  in  1  buffer holds an evicted line.
- buf_wdata  in  256  buffered line data.
- buf_address  in  32  buffered line address.
- complete_eviction  out  1  one-cycle pulse; buffer clears on this edge.
- l2_read  in  1  cache line read request; held until l2_resp.
- l2_address  in  32  read address.
- l2_rdata  out  256  read data; valid while l2_resp=1.
- l2_resp  out  1  one-cycle read completion.
- buf_hit  out  1  combinational: buf_valid & l2_read & line match.
- pmem_read  out  1  pmem read strobe; held until pmem_resp.
- pmem_write  out  1  pmem write strobe; held until pmem_resp.
- pmem_address  out  32  pmem address.
- pmem_wdata  out  256  pmem write data.
- pmem_rdata  in  256  pmem read data.
- pmem_resp  in  1  pmem completion, one cycle.

Behaviour:
- States: IDLE, READ, FWD, WRITE.
- Internal registers: req_addr (32), line_data (256), bypass_cnt (0..MAX_BYPASS).
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all registers cleared.
  - pmem_read, pmem_write, l2_resp, complete_eviction = 0; l2_rdata, pmem_address, pmem_wdata = 0.
  - An in-flight pmem transaction is abandoned; strobes drop immediately.
- IDLE decision each cycle, in priority order:
  - buf_hit=1: latch buf_wdata into line_data, go to FWD. A hit is never sent to pmem.
  - l2_read=1 and (buf_valid=0 or bypass_cnt<MAX_BYPASS): latch l2_address into req_addr, go to READ. If buf_valid=1, increment bypass_cnt (saturating).
  - buf_valid=1: latch buf_address into req_addr and buf_wdata into line_data, go to WRITE.
  - Otherwise stay in IDLE.
- FWD (exactly 1 cycle):
  - l2_resp=1, l2_rdata=line_data; next state IDLE.
  - Hit latency: 1 cycle after the IDLE decision edge.
- READ:
  - pmem_read=1, pmem_address=req_addr.
  - When pmem_resp=1: l2_resp=1 and l2_rdata=pmem_rdata combinationally in the same cycle; next state IDLE.
- WRITE:
  - pmem_write=1, pmem_address=req_addr, pmem_wdata=line_data.
  - When pmem_resp=1: complete_eviction=1 combinationally in the same cycle; bypass_cnt<=0; next state IDLE.
- pmem_read and pmem_write are never both high.
- Address and data are driven from latched registers, so mid-transaction changes on buf_* or l2_* are ignored.
- Requester protocol: the requester drops l2_read on the edge where it observes l2_resp. The block never issues a second response for the same request.
- bypass_cnt:
  - Holds while buf_valid=0.
  - When bypass_cnt=MAX_BYPASS and buf_valid=1, the next IDLE decision chooses WRITE (unless buf_hit), even with l2_read pending.
- Simultaneous l2_read and buf_valid with no hit: READ wins until the starvation limit is reached.
- buf_valid falling without complete_eviction is a protocol error. No recovery is required; the state machine still completes its current transaction.
- pmem_resp outside READ/WRITE is ignored.

Test Plan:
- Reset mid-write: enter WRITE with buf_address=0x0000_1000, assert rst_n=0 before pmem_resp -> pmem_write drops asynchronously, state IDLE, complete_eviction never pulses.
- Plain drain: buf_valid=1, buf_address=0x0000_1040, buf_wdata=0xA5 repeated, no reads, pmem_resp after 3 cycles -> pmem_write high for exactly those cycles with address 0x1040, complete_eviction single pulse coincident with pmem_resp.
- Forward hit: buf_valid=1, buf_address=0x2000_0020, l2_read at 0x2000_003C -> buf_hit=1, l2_resp one cycle later with l2_rdata=buf_wdata, no pmem_read.
- Read priority: buf_valid=1 at 0x100, l2_read at 0x400 -> pmem_read at 0x400 first, l2_resp=pmem_resp; WRITE to 0x100 follows once l2_read is low.
- Starvation (MAX_BYPASS=4): buf_valid=1 at 0x100, back-to-back non-hit reads -> 4 READ transactions, then WRITE to 0x100 before the 5th read; bypass_cnt=0 after complete_eviction.
- Latch stability: during READ at 0x400, change l2_address to 0x800 -> pmem_address stays 0x400 until pmem_resp.
